// File: rtl/ysyx_22050612_ifid_buf.sv
// IF/ID decoupling FIFO: buffers fetched {pc, inst} entries between IFU and IDU.
// Optional performance counters are enabled by defining YSYX_22050612_IFID_PERF_EN.
module ysyx_22050612_ifid_buf #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            in_ready,
  output logic            out_valid,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_inst,
  input  logic            out_ready,
  input  logic            flush
`ifdef YSYX_22050612_IFID_PERF_EN
  ,
  output logic [63:0]     perf_stall_cnt,
  output logic [63:0]     perf_flush_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Handshake: a transfer happens on a side only when its valid and ready are
  // both high at the rising edge; flush cancels both transfers in that cycle.
  // in_ready and out_valid depend on registered count only.

  logic [PC_W-1:0] mem_pc   [DEPTH];
  logic [31:0]     mem_inst [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  assign in_ready  = (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // An empty buffer presents zeros rather than stale storage.
  assign out_pc   = out_valid ? mem_pc[head]   : '0;
  assign out_inst = out_valid ? mem_inst[head] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
      end
    end else if (push) begin
      mem_pc[tail]   <= in_pc;
      mem_inst[tail] <= in_inst;
    end
  end

`ifdef YSYX_22050612_IFID_PERF_EN
  // Counters see raw activity and are cleared only by reset, never by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) perf_stall_cnt <= perf_stall_cnt + 64'd1;
      if (flush)                   perf_flush_cnt <= perf_flush_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22050612_ifid_buf.sv
// Self-checking bench for ysyx_22050612_ifid_buf against a queue-based model.
// Perf counter checks are active when YSYX_22050612_IFID_PERF_EN is defined.
module tb_ysyx_22050612_ifid_buf;
  localparam int DEPTH = 2;
  localparam int PC_W  = 64;
  localparam int VW    = PC_W + 34;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [PC_W-1:0] in_pc = '0;
  logic [31:0]     in_inst = '0;
  logic            in_ready;
  logic            out_valid;
  logic [PC_W-1:0] out_pc;
  logic [31:0]     out_inst;
  logic            out_ready = 1'b0;
  logic            flush = 1'b0;
`ifdef YSYX_22050612_IFID_PERF_EN
  logic [63:0]     perf_stall_cnt;
  logic [63:0]     perf_flush_cnt;
`endif

  ysyx_22050612_ifid_buf #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_pc(in_pc),
    .in_inst(in_inst),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_pc(out_pc),
    .out_inst(out_inst),
`ifdef YSYX_22050612_IFID_PERF_EN
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .out_ready(out_ready),
    .flush(flush)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO of {pc, inst} plus event counters.
  logic [PC_W+31:0] exp_q[$];
  logic [63:0]      m_stall;
  logic [63:0]      m_flush;
  int               checks;
  int               passed;

  function automatic logic [VW-1:0] exp_vec();
    logic [PC_W+31:0] h;
    h = '0;
    if (exp_q.size() != 0) h = exp_q[0];
    return {exp_q.size() < DEPTH, exp_q.size() != 0, h};
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {in_ready, out_valid, out_pc, out_inst};
  endfunction

  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Advance model by one edge from the inputs currently presented, then clock the DUT.
  task automatic tick();
    bit can_push;
    if (exp_q.size() != 0 && !out_ready) m_stall++;
    if (flush) m_flush++;
    if (flush) exp_q.delete();
    else begin
      can_push = in_valid && (exp_q.size() < DEPTH);
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (can_push) exp_q.push_back({in_pc, in_inst});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_stall = '0;
    m_flush = '0;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    checks++;
    if (act_vec() !== {1'b1, 1'b0, {(PC_W+32){1'b0}}})
      $display("FAIL reset_hold: got %h want %h", act_vec(), {1'b1, 1'b0, {(PC_W+32){1'b0}}});
    else passed++;
    rst = 1'b0;
    m_stall = '0;
    m_flush = '0;
    tick();
    checks++;
    if (act_vec() !== exp_vec()) $display("FAIL reset_release: got %h want %h", act_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_single_push();
    do_reset();
    drive(1'b1, 64'h8000_0000, 32'h0000_0413, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000 || out_inst !== 32'h0000_0413 || in_ready !== 1'b1)
      $display("FAIL single_push: got v=%b pc=%h inst=%h rdy=%b want v=1 pc=80000000 inst=00000413 rdy=1",
               out_valid, out_pc, out_inst, in_ready);
    else passed++;
    tick();
    checks++;
    if (act_vec() !== exp_vec()) $display("FAIL single_hold: got %h want %h", act_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_fill();
    do_reset();
    drive(1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h8000_0004, 32'h0000_0113, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h8000_0008, 32'h0000_0213, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_pc !== 64'h8000_0000 || act_vec() !== exp_vec())
        $display("FAIL fill_full: got %h want %h", act_vec(), exp_vec());
      else passed++;
      tick();
    end
  endtask

  task automatic test_drain_stream();
    logic [PC_W-1:0] want [3];
    want[0] = 64'h8000_0000;
    want[1] = 64'h8000_0004;
    want[2] = 64'h8000_0008;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(1'b1, 64'h8000_0008, 32'h0000_0213, 1'b1, 1'b0);
      else       drive(1'b1, 64'h8000_000C, 32'h0000_0313, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== want[i] || act_vec() !== exp_vec())
        $display("FAIL drain_order[%0d]: got pc=%h vec=%h want pc=%h vec=%h", i, out_pc, act_vec(), want[i], exp_vec());
      else passed++;
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (out_pc !== 64'h8000_000C || act_vec() !== exp_vec())
      $display("FAIL drain_tail: got %h want %h", act_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_push_pop();
    drive(1'b1, 64'h8000_0010, 32'h0000_0513, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_pc !== 64'h8000_0010 || exp_q.size() != 1 || act_vec() !== exp_vec())
      $display("FAIL push_pop: got %h want %h", act_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_flush();
    drive(1'b1, 64'h8000_0014, 32'h0000_0613, 1'b0, 1'b0);
    tick();
    checks++;
    if (in_ready !== 1'b0 || act_vec() !== exp_vec()) $display("FAIL flush_pre: got %h want %h", act_vec(), exp_vec());
    else passed++;
    drive(1'b1, 64'h8000_0018, 32'h0000_0713, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (act_vec() !== {1'b1, 1'b0, {(PC_W+32){1'b0}}})
      $display("FAIL flush_clear: got %h want %h", act_vec(), {1'b1, 1'b0, {(PC_W+32){1'b0}}});
    else passed++;
    tick();
    checks++;
    if (out_valid !== 1'b0 || act_vec() !== exp_vec()) $display("FAIL flush_not_stored: got %h want %h", act_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom,
            1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
      checks++;
      if (act_vec() !== exp_vec()) $display("FAIL random[%0d]: got %h want %h", i, act_vec(), exp_vec());
      else passed++;
`ifdef YSYX_22050612_IFID_PERF_EN
      checks++;
      if (perf_stall_cnt !== m_stall || perf_flush_cnt !== m_flush)
        $display("FAIL random_perf[%0d]: got %0d/%0d want %0d/%0d", i, perf_stall_cnt, perf_flush_cnt, m_stall, m_flush);
      else passed++;
`endif
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 64'h8000_0100, 32'h0000_0813, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h8000_0104, 32'h0000_0913, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 2 || act_vec() !== exp_vec()) $display("FAIL async_pre: got %h want %h", act_vec(), exp_vec());
    else passed++;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== '0 || out_inst !== '0 || in_ready !== 1'b1)
      $display("FAIL async_reset: got v=%b pc=%h inst=%h rdy=%b want v=0 pc=0 inst=0 rdy=1", out_valid, out_pc, out_inst, in_ready);
    else passed++;
`ifdef YSYX_22050612_IFID_PERF_EN
    checks++;
    if (perf_stall_cnt !== 64'd0 || perf_flush_cnt !== 64'd0)
      $display("FAIL async_perf: got %0d/%0d want 0/0", perf_stall_cnt, perf_flush_cnt);
    else passed++;
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_stall = '0;
    m_flush = '0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_vec() !== exp_vec()) $display("FAIL async_after[%0d]: got %h want %h", i, act_vec(), exp_vec());
      else passed++;
      tick();
    end
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    m_stall = '0;
    m_flush = '0;
    test_reset();
    test_single_push();
    test_fill();
    test_drain_stream();
    test_push_pop();
    test_flush();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
